sim_ctrl_slave: RTL and testbench

// Simulation-control bus slave, attached to the shared single-core bus next to the

---
 rtl/sim_ctrl_slave.sv | 146 ++++++++++++++
 tb/tb_sim_ctrl_slave.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sim_ctrl_slave.sv
// Simulation-control bus slave: coherent 64-bit cycle counter, scratch register
// and a sticky first-wins exit code, on a wired-OR single-core bus.
module sim_ctrl_slave #(
  parameter logic [31:0] baseAddr = 32'h70000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] bus_addrData_i,
  input  logic [3:0]  bus_byteEnables_i,
  input  logic [7:0]  bus_burstSize_i,
  input  logic        bus_readNWrite_i,
  input  logic        bus_beginTransaction_i,
  input  logic        bus_endTransaction_i,
  input  logic        bus_dataValid_i,
  output logic [31:0] bus_addrData_o,
  output logic        bus_endTransaction_o,
  output logic        bus_dataValid_o,
  output logic        bus_busy_o,
  output logic        bus_error_o,
  output logic        sim_done_o,
  output logic [31:0] exit_code_o
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, RD_END, WR, ERR} stateT;

  stateT       state;
  logic [63:0] cycleCount;
  logic [63:0] snapshot;
  logic [31:0] scratch;
  logic [1:0]  word;
  logic [7:0]  beatsLeft;
  logic        wrActive;
  logic [3:0]  byteEn;
  logic [31:0] laneMask;
  logic [31:0] maskedData;
  logic        addrHit;
  logic        unusedAddrBits;

  assign addrHit        = bus_addrData_i[31:8] == baseAddr[31:8];
  assign laneMask       = {{8{byteEn[3]}}, {8{byteEn[2]}}, {8{byteEn[1]}}, {8{byteEn[0]}}};
  assign maskedData     = bus_addrData_i & laneMask;
  assign bus_busy_o     = 1'b0;
  assign unusedAddrBits = ^{bus_addrData_i[1:0], baseAddr[7:0]};

  // Word 0 is the write-only EXIT register and always reads back as zero.
  function automatic logic [31:0] regRead(input logic [1:0] idx, input logic [63:0] snap,
                                          input logic [31:0] scr);
    case (idx)
      2'd1:    regRead = snap[31:0];
      2'd2:    regRead = snap[63:32];
      2'd3:    regRead = scr;
      default: regRead = 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) cycleCount <= 64'd0;
    else       cycleCount <= cycleCount + 64'd1;
  end

  // Bus outputs are registered for the state being entered, so they are zero
  // in every cycle the slave is not presenting a beat or a strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state                <= IDLE;
      snapshot             <= 64'd0;
      scratch              <= 32'd0;
      word                 <= 2'd0;
      beatsLeft            <= 8'd0;
      wrActive             <= 1'b0;
      byteEn               <= 4'd0;
      bus_addrData_o       <= 32'd0;
      bus_dataValid_o      <= 1'b0;
      bus_endTransaction_o <= 1'b0;
      bus_error_o          <= 1'b0;
      sim_done_o           <= 1'b0;
      exit_code_o          <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_beginTransaction_i && addrHit) begin
            word      <= bus_addrData_i[3:2];
            beatsLeft <= bus_burstSize_i;
            byteEn    <= bus_byteEnables_i;
            wrActive  <= 1'b1;
            if (bus_addrData_i[7:4] != 4'd0) begin
              state       <= ERR;
              bus_error_o <= 1'b1;
            end else if (bus_readNWrite_i) begin
              state    <= RD_WAIT;
              snapshot <= cycleCount;
            end else begin
              state <= WR;
            end
          end
        end
        RD_WAIT: begin
          state           <= RD_DATA;
          bus_dataValid_o <= 1'b1;
          bus_addrData_o  <= regRead(word, snapshot, scratch);
          word            <= word + 2'd1;
        end
        RD_DATA: begin
          if (beatsLeft == 8'd0) begin
            state                <= RD_END;
            bus_dataValid_o      <= 1'b0;
            bus_addrData_o       <= 32'd0;
            bus_endTransaction_o <= 1'b1;
          end else begin
            beatsLeft      <= beatsLeft - 8'd1;
            bus_addrData_o <= regRead(word, snapshot, scratch);
            word           <= word + 2'd1;
          end
        end
        RD_END: begin
          state                <= IDLE;
          bus_endTransaction_o <= 1'b0;
        end
        WR: begin
          if (bus_dataValid_i && wrActive) begin
            case (word)
              2'd0: begin
                if (!sim_done_o) begin
                  exit_code_o <= maskedData;
                  sim_done_o  <= 1'b1;
                end
              end
              2'd3:    scratch <= (scratch & ~laneMask) | maskedData;
              default: ;
            endcase
            word <= word + 2'd1;
            if (beatsLeft == 8'd0) wrActive  <= 1'b0;
            else                   beatsLeft <= beatsLeft - 8'd1;
          end
          if (bus_endTransaction_i) state <= IDLE;
        end
        ERR: begin
          state       <= IDLE;
          bus_error_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_ctrl_slave.sv
// Directed self-checking bench for sim_ctrl_slave: counter reads, scratch access,
// burst wrap, first-wins exit, error window and reset mid-transaction.
module tb_sim_ctrl_slave;

  logic        clk;
  logic        rst;
  logic [31:0] addrData;
  logic [3:0]  byteEn;
  logic [7:0]  burstSize;
  logic        readNWrite;
  logic        beginTr;
  logic        endTrIn;
  logic        dataValidIn;
  logic [31:0] dataOut;
  logic        endTrOut;
  logic        dataValidOut;
  logic        busy;
  logic        busError;
  logic        simDone;
  logic [31:0] exitCode;

  int          testCount = 0;
  int          failCount = 0;
  logic [63:0] benchCyc;
  logic [63:0] expSnap;
  logic [31:0] rdBeats [0:15];
  int          rdCount, endCount, errCount, firstK, endK;

  sim_ctrl_slave #(.baseAddr(32'h70000000)) dut (
    .clk_i(clk), .rst_i(rst),
    .bus_addrData_i(addrData), .bus_byteEnables_i(byteEn),
    .bus_burstSize_i(burstSize), .bus_readNWrite_i(readNWrite),
    .bus_beginTransaction_i(beginTr), .bus_endTransaction_i(endTrIn),
    .bus_dataValid_i(dataValidIn),
    .bus_addrData_o(dataOut), .bus_endTransaction_o(endTrOut),
    .bus_dataValid_o(dataValidOut), .bus_busy_o(busy), .bus_error_o(busError),
    .sim_done_o(simDone), .exit_code_o(exitCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference count of clock edges seen since reset was last released.
  always @(posedge clk) begin
    if (rst) benchCyc <= 64'd0;
    else     benchCyc <= benchCyc + 64'd1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic checkIdleBus(input string tag);
    checkOutput({tag, ".data"}, {32'd0, dataOut}, 64'd0);
    checkOutput({tag, ".ctl"}, {60'd0, dataValidOut, endTrOut, busError, busy}, 64'd0);
  endtask

  task automatic applyReset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    checkIdleBus("reset");
    checkOutput("resetDone", {63'd0, simDone}, 64'd0);
    checkOutput("resetCode", {32'd0, exitCode}, 64'd0);
    rst = 1'b0;
  endtask

  task automatic applyStimulusRead(input logic [31:0] addr, input logic [7:0] burst);
    @(negedge clk);
    expSnap    = benchCyc;
    addrData   = addr;
    burstSize  = burst;
    readNWrite = 1'b1;
    beginTr    = 1'b1;
    rdCount = 0; endCount = 0; errCount = 0; firstK = -1; endK = -1;
    for (int k = 1; k <= int'(burst) + 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        beginTr  = 1'b0;
        addrData = 32'd0;
      end
      if (dataValidOut) begin
        if (firstK < 0) firstK = k;
        if (rdCount < 16) rdBeats[rdCount] = dataOut;
        rdCount++;
      end
      if (endTrOut) begin
        endCount++;
        if (endK < 0) endK = k;
      end
      if (busError) errCount++;
    end
  endtask

  task automatic applyStimulusWrite(input logic [31:0] addr, input logic [3:0] be, input logic [7:0] burst,
                                    input logic [31:0] d0, input logic [31:0] d1, input int nBeats);
    @(negedge clk);
    addrData   = addr;
    byteEn     = be;
    burstSize  = burst;
    readNWrite = 1'b0;
    beginTr    = 1'b1;
    for (int i = 0; i < nBeats; i++) begin
      @(negedge clk);
      beginTr     = 1'b0;
      addrData    = (i == 0) ? d0 : d1;
      dataValidIn = 1'b1;
      endTrIn     = (i == nBeats - 1);
    end
    @(negedge clk);
    dataValidIn = 1'b0;
    endTrIn     = 1'b0;
    addrData    = 32'd0;
  endtask

  initial begin
    rst = 1'b1; addrData = 0; byteEn = 0; burstSize = 0; readNWrite = 0;
    beginTr = 0; endTrIn = 0; dataValidIn = 0;

    // Reset, then a counter read one edge after release sees the value 1.
    applyReset(11);
    applyStimulusRead(32'h70000004, 8'd0);
    checkOutput("t1.latency", firstK, 2);
    checkOutput("t1.beats", rdCount, 1);
    checkOutput("t1.cycLo", {32'd0, rdBeats[0]}, 64'd1);

    // Masked scratch write and read-back with a one-cycle end strobe.
    applyStimulusWrite(32'h7000000C, 4'b0011, 8'd0, 32'hDEADBEEF, 32'd0, 1);
    applyStimulusRead(32'h7000000C, 8'd0);
    checkOutput("t2.scratch", {32'd0, rdBeats[0]}, 64'h0000BEEF);
    checkOutput("t2.endAt", endK, 3);
    checkOutput("t2.endCount", endCount, 1);

    // Burst read LO, HI, SCRATCH from one coherent snapshot.
    applyStimulusRead(32'h70000004, 8'd2);
    checkOutput("t3.beats", rdCount, 3);
    checkOutput("t3.counter", {rdBeats[1], rdBeats[0]}, expSnap);
    checkOutput("t3.scratch", {32'd0, rdBeats[2]}, 64'h0000BEEF);
    checkOutput("t3.endAt", endK, 5);

    // Burst write wraps from SCRATCH onto EXIT.
    applyStimulusWrite(32'h7000000C, 4'hF, 8'd1, 32'h11, 32'h22, 2);
    checkOutput("t4.done", {63'd0, simDone}, 64'd1);
    checkOutput("t4.code", {32'd0, exitCode}, 64'h22);
    applyStimulusRead(32'h7000000C, 8'd0);
    checkOutput("t4.scratch", {32'd0, rdBeats[0]}, 64'h11);

    // Extra beats past burst+1 are dropped, then first EXIT wins, reset clears.
    applyReset(3);
    applyStimulusWrite(32'h7000000C, 4'hF, 8'd0, 32'hAA, 32'h99, 2);
    checkOutput("t5.extraDone", {63'd0, simDone}, 64'd0);
    applyStimulusRead(32'h7000000C, 8'd0);
    checkOutput("t5.extraScratch", {32'd0, rdBeats[0]}, 64'hAA);
    applyStimulusWrite(32'h70000000, 4'hF, 8'd0, 32'd5, 32'd0, 1);
    checkOutput("t5.done", {63'd0, simDone}, 64'd1);
    checkOutput("t5.code5", {32'd0, exitCode}, 64'd5);
    applyStimulusWrite(32'h70000000, 4'hF, 8'd0, 32'd7, 32'd0, 1);
    checkOutput("t5.codeKept", {32'd0, exitCode}, 64'd5);
    applyStimulusRead(32'h70000000, 8'd0);
    checkOutput("t5.exitReads0", {32'd0, rdBeats[0]}, 64'd0);
    applyReset(2);

    // Unmapped offset errors for one cycle; foreign address gets no response.
    applyStimulusRead(32'h70000040, 8'd0);
    checkOutput("t6.errCount", errCount, 1);
    checkOutput("t6.errBeats", rdCount, 0);
    checkOutput("t6.errEnd", endCount, 0);
    applyStimulusRead(32'h60000000, 8'd0);
    checkOutput("t6.missAll", rdCount + endCount + errCount, 0);

    // Reset during the data phase silences the bus; the next read is normal.
    @(negedge clk);
    addrData = 32'h70000004; burstSize = 8'd3; readNWrite = 1'b1; beginTr = 1'b1;
    @(negedge clk);
    beginTr = 1'b0; addrData = 32'd0;
    @(negedge clk);
    checkOutput("t7.midBeat", {63'd0, dataValidOut}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    checkIdleBus("t7.afterReset");
    rst = 1'b0;
    applyStimulusRead(32'h70000004, 8'd0);
    checkOutput("t7.beats", rdCount, 1);
    checkOutput("t7.cycLo", {32'd0, rdBeats[0]}, 64'd1);
    checkOutput("t7.endCount", endCount, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
